// File: rtl/shadow_stack_pkg.sv
// Shared constants for the shadow-stack return-address LIFO.
// SHADOW_STACK_PARITY_EN adds one even-parity bit per stored entry.
package shadow_stack_pkg;

   localparam int SS_DW    = 32;
   localparam int SS_DEPTH = 32;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

`ifdef SHADOW_STACK_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/shadow_stack_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read data is valid the cycle after rd_en_i and holds until the next read.
module shadow_stack_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_dat_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_dat_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rd_dat_q;

   // Array and read register are intentionally not reset so they map to block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
      if (rd_en_i) begin
         rd_dat_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/shadow_stack_mem.sv
// Return-address LIFO with sticky over/underflow faults; pop data appears 1 cycle after the strobe.
// No backpressure: every st_en cycle is one operation (SHADOW_STACK_PARITY_EN adds st_parity_err_o).
module shadow_stack_mem
   import shadow_stack_pkg::*;
#(
   parameter int DEPTH = SS_DEPTH,
   parameter int AW    = 5,
   parameter int DW    = SS_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_en,
   input  logic          st_push_pop,
   input  logic [DW-1:0] st_data_i,
   input  logic          st_clear,
   output logic [DW-1:0] st_data_o,
   output logic          st_valid_o,
   output logic [AW:0]   st_count_o,
   output logic          st_full_o,
   output logic          st_empty_o,
   output logic          st_overflow_o,
`ifdef SHADOW_STACK_PARITY_EN
   output logic          st_parity_err_o,
`endif
   output logic          st_underflow_o
);

   localparam int          RW       = DW + PAR_W;
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW:0]   count_q, count_d;
   logic          valid_q, valid_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          full, empty;
   logic          op_push, op_pop;
   logic          do_push, do_pop;
   logic [AW:0]   count_dec;
   logic [RW-1:0] wr_word;
   logic [RW-1:0] rd_word;

   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign count_dec = count_q - CNT_ONE;

   assign op_push = st_en & (st_push_pop == OP_PUSH);
   assign op_pop  = st_en & (st_push_pop == OP_POP);

   // Memory side effects must also respect reset and clear priority.
   assign do_push = op_push & ~full  & ~st_clear & ~reset;
   assign do_pop  = op_pop  & ~empty & ~st_clear & ~reset;

`ifdef SHADOW_STACK_PARITY_EN
   assign wr_word = {^st_data_i, st_data_i};
`else
   assign wr_word = st_data_i;
`endif

   shadow_stack_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (RW)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (do_push),
      .wr_addr_i (count_q[AW-1:0]),
      .wr_dat_i  (wr_word),
      .rd_en_i   (do_pop),
      .rd_addr_i (count_dec[AW-1:0]),
      .rd_dat_o  (rd_word)
   );

   always_comb begin
      count_d = count_q;
      valid_d = 1'b0;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (st_clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (op_push) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end else if (op_pop) begin
         if (empty) begin
            unf_d  = 1'b1;
            zero_d = 1'b1;
         end else begin
            count_d = count_dec;
            valid_d = 1'b1;
            zero_d  = 1'b0;
         end
      end
   end

   // zero_q masks the RAM read register after reset or a pop on empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign st_data_o      = zero_q ? '0 : rd_word[DW-1:0];
   assign st_valid_o     = valid_q;
   assign st_count_o     = count_q;
   assign st_full_o      = full;
   assign st_empty_o     = empty;
   assign st_overflow_o  = ovf_q;
   assign st_underflow_o = unf_q;

`ifdef SHADOW_STACK_PARITY_EN
   logic perr_q, perr_d;
   logic par_mism;

   assign par_mism = (^rd_word[DW-1:0]) != rd_word[DW];

   always_comb begin
      perr_d = perr_q | (valid_q & par_mism);
      if (st_clear) begin
         perr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   // Raised in the same cycle as st_valid_o, then held by perr_q.
   assign st_parity_err_o = perr_q | (valid_q & par_mism);
`endif

endmodule

// File: tb/tb_shadow_stack_mem.sv
// Randomized and directed bench for shadow_stack_mem against a queue-based LIFO model.
module tb_shadow_stack_mem;
   import shadow_stack_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int DW    = SS_DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_en;
   logic          st_push_pop;
   logic [DW-1:0] st_data_i;
   logic          st_clear;
   logic [DW-1:0] st_data_o;
   logic          st_valid_o;
   logic [AW:0]   st_count_o;
   logic          st_full_o;
   logic          st_empty_o;
   logic          st_overflow_o;
   logic          st_underflow_o;
`ifdef SHADOW_STACK_PARITY_EN
   logic          st_parity_err_o;
`endif

   shadow_stack_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .st_en          (st_en),
      .st_push_pop    (st_push_pop),
      .st_data_i      (st_data_i),
      .st_clear       (st_clear),
      .st_data_o      (st_data_o),
      .st_valid_o     (st_valid_o),
      .st_count_o     (st_count_o),
      .st_full_o      (st_full_o),
      .st_empty_o     (st_empty_o),
      .st_overflow_o  (st_overflow_o),
`ifdef SHADOW_STACK_PARITY_EN
      .st_parity_err_o(st_parity_err_o),
`endif
      .st_underflow_o (st_underflow_o)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue as the stack plus output flags.
   logic [DW-1:0] m_stack[$];
   logic [DW-1:0] m_data;
   logic          m_valid, m_ovf, m_unf, m_perr, m_inject;
   logic          chk_en = 1'b0;
   int            n_tot = 0;
   int            n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_step(input logic en, input logic pp, input logic [DW-1:0] d,
                             input logic clr, input logic rst);
      if (rst) begin
         m_stack.delete();
         m_data = '0; m_valid = 0; m_ovf = 0; m_unf = 0; m_perr = 0;
      end else if (clr) begin
         m_stack.delete();
         m_valid = 0; m_ovf = 0; m_unf = 0; m_perr = 0;
      end else if (en && pp) begin
         m_valid = 0;
         if (m_stack.size() == DEPTH) m_ovf = 1;
         else m_stack.push_back(d);
      end else if (en) begin
         if (m_stack.size() == 0) begin
            m_data = '0; m_valid = 0; m_unf = 1;
         end else begin
            m_data = m_stack.pop_back(); m_valid = 1;
            if (m_inject) begin m_perr = 1; m_inject = 0; end
         end
      end else begin
         m_valid = 0;
      end
   endtask

   task automatic cyc(input logic en, input logic pp, input logic [DW-1:0] d,
                      input logic clr, input logic rst);
      st_en = en; st_push_pop = pp; st_data_i = d; st_clear = clr; reset = rst;
      @(posedge clk);
      model_step(en, pp, d, clr, rst);
      @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] d); cyc(1, 1, d, 0, 0); endtask
   task automatic pop();                        cyc(1, 0, '0, 0, 0); endtask
   task automatic idle();                       cyc(0, 0, '0, 0, 0); endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",     st_count_o,     m_stack.size());
         chk("full",      st_full_o,      m_stack.size() == DEPTH);
         chk("empty",     st_empty_o,     m_stack.size() == 0);
         chk("data",      st_data_o,      m_data);
         chk("valid",     st_valid_o,     m_valid);
         chk("overflow",  st_overflow_o,  m_ovf);
         chk("underflow", st_underflow_o, m_unf);
`ifdef SHADOW_STACK_PARITY_EN
         chk("parity_err", st_parity_err_o, m_perr);
`endif
      end
   end

   initial begin
      m_inject = 0;
      st_en = 0; st_push_pop = 0; st_data_i = '0; st_clear = 0; reset = 1;
      @(negedge clk);
      cyc(0, 0, '0, 0, 1);
      chk_en = 1;
      idle();
      chk("rst_count", st_count_o, 0);
      chk("rst_empty", st_empty_o, 1);
      chk("rst_full",  st_full_o,  0);
      chk("rst_data",  st_data_o,  0);
      chk("rst_ovf",   st_overflow_o, 0);

      push(32'h1000); push(32'h2000); push(32'h3000);
      pop(); chk("pop1_data", st_data_o, 32'h3000); chk("pop1_vld", st_valid_o, 1);
      pop(); chk("pop2_data", st_data_o, 32'h2000);
      pop(); chk("pop3_data", st_data_o, 32'h1000);
      idle(); chk("pop_vld_pulse", st_valid_o, 0); chk("pop_hold", st_data_o, 32'h1000);
      chk("drain_count", st_count_o, 0);

      for (int i = 0; i < 5; i++) begin
         push(32'hA + i);
         if (i == 3) chk("full_at4", st_full_o, 1);
      end
      chk("ovf_at5", st_overflow_o, 1);
      for (int i = 0; i < 4; i++) begin
         pop(); chk("ovf_pop", st_data_o, 32'hD - i);
      end

      pop();
      chk("unf_flag", st_underflow_o, 1); chk("unf_data", st_data_o, 0); chk("unf_vld", st_valid_o, 0);
      push(32'h55); pop();
      chk("after_unf_data", st_data_o, 32'h55); chk("unf_sticky", st_underflow_o, 1);

      cyc(1, 1, 32'h77, 1, 0);
      chk("clr_count", st_count_o, 0); chk("clr_ovf", st_overflow_o, 0); chk("clr_unf", st_underflow_o, 0);
      pop(); chk("clr_nowrite", st_underflow_o, 1);

      push(32'h99); cyc(1, 1, 32'h11, 0, 1);
      chk("rst_wins", st_count_o, 0);

`ifdef SHADOW_STACK_PARITY_EN
      push(32'h1234);
      dut.u_ram.mem_q[0][DW] = ~dut.u_ram.mem_q[0][DW];
      m_inject = 1;
      pop(); chk("perr_set", st_parity_err_o, 1); chk("perr_vld", st_valid_o, 1);
      idle(); chk("perr_sticky", st_parity_err_o, 1);
      cyc(0, 0, '0, 1, 0); chk("perr_clr", st_parity_err_o, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic en, pp, clr, rst;
         en  = ($urandom_range(0, 99) < 75);
         pp  = $urandom_range(0, 1);
         clr = ($urandom_range(0, 99) < 3);
         rst = ($urandom_range(0, 199) < 1);
         cyc(en, pp, $urandom, clr, rst);
      end

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
